bmp180_calib_wr: RTL and testbench

BMP180_CALIB_WR -- requirements
Module: bmp180_calib_wr

---
 rtl/bmp180_calib_wr.sv | 116 +++++++++++
 tb/tb_bmp180_calib_wr.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bmp180_calib_wr.sv
// BMP180 calibration loader: packs MSB/LSB byte pairs into NUM_WORDS RAM writes.
// Optional macro CALIB_CHECK_EN flags 16'h0000 / 16'hFFFF coefficients on O_ERR.
module bmp180_calib_wr #(
    parameter int unsigned DATA_OPM_SZ = 16,
    parameter int unsigned ADDR_OPM_SZ = 4,
    parameter int unsigned NUM_WORDS   = 11
) (
    input  logic                   CLK,
    input  logic                   RST_n,
    input  logic                   I_START,
    input  logic                   I_ABORT,
    input  logic [7:0]             I_BYTE,
    input  logic                   I_BYTE_VLD,
    output logic                   O_WE,
    output logic [ADDR_OPM_SZ-1:0] O_ADDR_OPM,
    output logic [DATA_OPM_SZ-1:0] O_DATA_WR_OPM,
    output logic                   O_BUSY,
    output logic                   O_DONE,
    output logic                   O_ERR
);

    localparam logic [ADDR_OPM_SZ-1:0] LAST_IDX = ADDR_OPM_SZ'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSB  = 2'd1,
        LSB  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [ADDR_OPM_SZ-1:0] r_cnt;
    logic [7:0]             r_msb;

    logic                   w_start_acc;
    logic                   w_word_wr;
    logic [DATA_OPM_SZ-1:0] w_word;

    assign w_start_acc = (r_state == IDLE) && I_START;
    // Abort wins over a byte arriving on the same cycle.
    assign w_word_wr   = (r_state == LSB) && !I_ABORT && I_BYTE_VLD;
    assign w_word      = DATA_OPM_SZ'({r_msb, I_BYTE});

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_msb         <= '0;
            O_WE          <= 1'b0;
            O_ADDR_OPM    <= '0;
            O_DATA_WR_OPM <= '0;
            O_BUSY        <= 1'b0;
            O_DONE        <= 1'b0;
        end else begin
            O_WE   <= 1'b0;
            O_DONE <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_acc) begin
                        r_state <= MSB;
                        r_cnt   <= '0;
                        O_BUSY  <= 1'b1;
                    end
                end
                MSB: begin
                    if (I_ABORT) begin
                        r_state <= IDLE;
                        O_BUSY  <= 1'b0;
                    end else if (I_BYTE_VLD) begin
                        r_msb   <= I_BYTE;
                        r_state <= LSB;
                    end
                end
                LSB: begin
                    if (I_ABORT) begin
                        r_state <= IDLE;
                        O_BUSY  <= 1'b0;
                    end else if (w_word_wr) begin
                        O_WE          <= 1'b1;
                        O_ADDR_OPM    <= r_cnt;
                        O_DATA_WR_OPM <= w_word;
                        // Returning straight to MSB lets a byte during O_WE start the next word.
                        if (r_cnt == LAST_IDX) begin
                            r_state <= DONE;
                            O_BUSY  <= 1'b0;
                        end else begin
                            r_cnt   <= r_cnt + ADDR_OPM_SZ'(1);
                            r_state <= MSB;
                        end
                    end
                end
                DONE: begin
                    O_DONE  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CALIB_CHECK_EN
    // Sticky flag for erased/unprogrammed coefficients; the word is still written.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            O_ERR <= 1'b0;
        end else if (w_start_acc) begin
            O_ERR <= 1'b0;
        end else if (w_word_wr && ((w_word == '0) || (w_word == '1))) begin
            O_ERR <= 1'b1;
        end
    end
`else
    assign O_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_bmp180_calib_wr.sv
// Bench for bmp180_calib_wr: directed scenarios plus random byte streams vs a byte-count model.
`timescale 1ns/1ps
module tb_bmp180_calib_wr;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned NW = 11;

    logic          CLK;
    logic          RST_n;
    logic          I_START;
    logic          I_ABORT;
    logic [7:0]    I_BYTE;
    logic          I_BYTE_VLD;
    logic          O_WE;
    logic [AW-1:0] O_ADDR_OPM;
    logic [DW-1:0] O_DATA_WR_OPM;
    logic          O_BUSY;
    logic          O_DONE;
    logic          O_ERR;

    bmp180_calib_wr #(.DATA_OPM_SZ(DW), .ADDR_OPM_SZ(AW), .NUM_WORDS(NW)) dut (
        .CLK(CLK), .RST_n(RST_n), .I_START(I_START), .I_ABORT(I_ABORT),
        .I_BYTE(I_BYTE), .I_BYTE_VLD(I_BYTE_VLD), .O_WE(O_WE),
        .O_ADDR_OPM(O_ADDR_OPM), .O_DATA_WR_OPM(O_DATA_WR_OPM),
        .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_ERR(O_ERR)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;
    string g_tag = "reset";

    // Reference model: a sequence is a count of accepted bytes; every second byte completes a word.
    bit            m_active;
    bit            m_done_pend;
    int            m_nbytes;
    logic [7:0]    m_msb;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            m_err;
    bit            e_we;
    bit            e_done;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s.%s: observed %0h expected %0h", g_tag, name, obs, exp);
    endtask

    task automatic check_all();
        chk("we",   32'(O_WE),          32'(e_we));
        chk("busy", 32'(O_BUSY),        32'(m_active));
        chk("done", 32'(O_DONE),        32'(e_done));
        chk("err",  32'(O_ERR),         32'(m_err));
        chk("addr", 32'(O_ADDR_OPM),    32'(m_addr));
        chk("data", 32'(O_DATA_WR_OPM), 32'(m_data));
    endtask

    task automatic model_reset();
        m_active = 0; m_done_pend = 0; m_nbytes = 0; m_msb = '0;
        m_addr = '0; m_data = '0; m_err = 0; e_we = 0; e_done = 0;
    endtask

    task automatic model_step(input logic st, input logic ab, input logic [7:0] b, input logic v);
        e_we = 0;
        e_done = 0;
        if (m_done_pend) begin
            e_done = 1;
            m_done_pend = 0;
        end else if (!m_active) begin
            if (st) begin
                m_active = 1; m_nbytes = 0; m_err = 0;
            end
        end else if (ab) begin
            m_active = 0;
        end else if (v) begin
            if (m_nbytes % 2 == 0) begin
                m_msb = b;
            end else begin
                e_we   = 1;
                m_addr = AW'(m_nbytes / 2);
                m_data = {m_msb, b};
`ifdef CALIB_CHECK_EN
                if (m_data == 16'h0000 || m_data == 16'hFFFF) m_err = 1;
`endif
                if (m_nbytes + 1 == int'(2 * NW)) begin
                    m_active = 0; m_done_pend = 1;
                end
            end
            m_nbytes++;
        end
    endtask

    task automatic step(input logic st, input logic ab, input logic [7:0] b, input logic v);
        I_START = st; I_ABORT = ab; I_BYTE = b; I_BYTE_VLD = v;
        @(posedge CLK);
        model_step(st, ab, b, v);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b0, 1'b0, b, 1'b1);
    endtask

    task automatic reset_mid();
        RST_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge CLK);
        I_START = 0; I_ABORT = 0; I_BYTE = '0; I_BYTE_VLD = 0;
        RST_n = 1'b1;
    endtask

    function automatic logic [7:0] pick_byte();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 8'h00;
        if (r == 1) return 8'hFF;
        return 8'($urandom);
    endfunction

    initial begin
        logic [7:0] b;
        model_reset();
        RST_n = 1'b0; I_START = 0; I_ABORT = 0; I_BYTE = '0; I_BYTE_VLD = 0;
        repeat (2) @(posedge CLK);
        #1;
        check_all();
        @(negedge CLK);
        RST_n = 1'b1;

        g_tag = "b2b";
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 22; i++) send(8'(i));
        repeat (3) idle();

        g_tag = "gap";
        step(1'b1, 1'b0, 8'h00, 1'b0);
        send(8'hAB);
        repeat (3) idle();
        send(8'hCD);
        idle();
        step(1'b0, 1'b1, 8'h00, 1'b0);
        idle();

        g_tag = "ign";
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'($urandom), 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 22; i++) begin
            b = 8'(8'h30 + i);
            step((i % 3) == 0, 1'b0, b, 1'b1);
            if (i % 5 == 0) step(1'b1, 1'b0, 8'h00, 1'b0);
        end
        repeat (3) idle();

        g_tag = "abort";
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 9; i++) send(8'(8'h40 + i));
        step(1'b0, 1'b1, 8'h55, 1'b1);
        repeat (3) idle();

        g_tag = "rst";
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 15; i++) send(8'(8'h60 + i));
        reset_mid();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        send(8'h12);
        send(8'h34);
        idle();
        step(1'b0, 1'b1, 8'h00, 1'b0);
        idle();

        g_tag = "ffff";
        step(1'b1, 1'b0, 8'h00, 1'b0);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'hFF); send(8'hFF);
        for (int i = 0; i < 16; i++) send(8'(8'h80 + i));
        repeat (2) idle();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        idle();
        step(1'b0, 1'b1, 8'h00, 1'b0);
        idle();

        g_tag = "rand";
        for (int s = 0; s < 20; s++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            for (int c = 0; c < 120 && (m_active || m_done_pend); c++) begin
                step($urandom_range(0, 9) == 0, $urandom_range(0, 99) < 2,
                     pick_byte(), $urandom_range(0, 3) != 0);
            end
            repeat (2) idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
